// File: rtl/enc_pkg.sv
// Shared types and widths for the sequential 8-to-3 encoder.
// Holds the scan state enum and the vector/index/count widths.
package enc_pkg;

  localparam int VEC_W = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/prio_enc8to3.sv
// Combinational priority encoder: vec -> index of highest or lowest set bit.
// Ports: vec (8), idx (3), any (1). MSB_FIRST=1 picks highest, 0 lowest.
module prio_enc8to3
  import enc_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic [VEC_W-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // The last match in each loop wins, so the
  // scan direction sets the priority.
  always_comb begin
    idx = '0;
    any = |vec;
    if (MSB_FIRST) begin
      for (int i = 0; i < VEC_W; i++)
        if (vec[i]) idx = IDX_W'(i);
    end else begin
      for (int i = VEC_W - 1; i >= 0; i--)
        if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/enc8to3_scan.sv
// Sequential 8-to-3 encoder: accepts a vector, emits each set index per beat.
// Ports: clk, rst_n, en, in/in_valid/in_ready, out/out_valid/out_ready, out_last, cnt.
module enc8to3_scan
  import enc_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [VEC_W-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CNT_W-1:0] cnt
);

  state_t           state;
  state_t           state_n;
  logic [VEC_W-1:0] vec_r;
  logic [VEC_W-1:0] vec_n;
  logic [IDX_W-1:0] idx;
  logic             any;
  logic [CNT_W-1:0] pc;
  logic             scan;

  prio_enc8to3 #(
    .MSB_FIRST(MSB_FIRST)
  ) u_prio (
    .vec(vec_r),
    .idx(idx),
    .any(any)
  );

  always_comb begin
    pc = '0;
    for (int i = 0; i < VEC_W; i++)
      pc = pc + CNT_W'(vec_r[i]);
  end

  assign scan      = (state == SCAN);
  // rst_n gates in_ready so nothing is offered
  // while the block is held in reset.
  assign in_ready  = rst_n & en & ~scan;
  assign out_valid = scan;
  assign out       = scan ? idx : '0;
  assign cnt       = scan ? pc : '0;
  assign out_last  = scan & (pc == CNT_W'(1));

  always_comb begin
    state_n = state;
    vec_n   = vec_r;
    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          vec_n = in;
          if (in != '0) state_n = SCAN;
        end
      end
      SCAN: begin
        if (out_ready && any) begin
          vec_n = vec_r & ~(VEC_W'(1) << idx);
          if (out_last) state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        vec_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      vec_r <= '0;
    end else begin
      state <= state_n;
      vec_r <= vec_n;
    end
  end

endmodule

// File: tb/tb_enc8to3_scan.sv
// Bench for enc8to3_scan: both priority orders run side by side.
// Queue-based model of the index stream; directed steps then random traffic.
module tb_enc8to3_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] in;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready1, in_ready0;
  logic [2:0] out1, out0;
  logic       out_valid1, out_valid0;
  logic       out_last1, out_last0;
  logic [3:0] cnt1, cnt0;

  int total = 0;
  int bad   = 0;

  // Expected index streams still to be emitted
  int q1[$];
  int q0[$];

  always #5 clk = ~clk;

  enc8to3_scan #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in(in), .in_valid(in_valid), .in_ready(in_ready1),
    .out(out1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_last(out_last1), .cnt(cnt1)
  );

  enc8to3_scan #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in(in), .in_valid(in_valid), .in_ready(in_ready0),
    .out(out0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_last(out_last0), .cnt(cnt0)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic       busy;
    logic [2:0] e1, e0;
    logic [3:0] ec;
    busy = (q1.size() != 0);
    e1   = busy ? 3'(q1[0]) : 3'd0;
    e0   = busy ? 3'(q0[0]) : 3'd0;
    ec   = 4'(q1.size());
    chk("in_ready1",  {7'd0, in_ready1},  {7'd0, rst_n & en & ~busy});
    chk("in_ready0",  {7'd0, in_ready0},  {7'd0, rst_n & en & ~busy});
    chk("out_valid1", {7'd0, out_valid1}, {7'd0, busy});
    chk("out_valid0", {7'd0, out_valid0}, {7'd0, busy});
    chk("out1",       {5'd0, out1},       {5'd0, e1});
    chk("out0",       {5'd0, out0},       {5'd0, e0});
    chk("cnt1",       {4'd0, cnt1},       {4'd0, ec});
    chk("cnt0",       {4'd0, cnt0},       {4'd0, ec});
    chk("out_last1",  {7'd0, out_last1},  {7'd0, ec == 4'd1});
    chk("out_last0",  {7'd0, out_last0},  {7'd0, ec == 4'd1});
  endtask

  // Check at the negedge, then advance one clock and
  // update the model from the handshakes seen there.
  task automatic tick();
    logic       acc, beat;
    logic [7:0] v;
    @(negedge clk);
    check_all();
    acc  = rst_n && en && in_valid && (q1.size() == 0);
    beat = rst_n && out_ready && (q1.size() != 0);
    v    = in;
    @(posedge clk);
    #1;
    if (beat) begin
      void'(q1.pop_front());
      void'(q0.pop_front());
    end
    if (acc) begin
      for (int i = 7; i >= 0; i--) if (v[i]) q1.push_back(i);
      for (int i = 0; i < 8; i++)  if (v[i]) q0.push_back(i);
    end
  endtask

  task automatic send(input logic [7:0] v);
    in       = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in       = $urandom();
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b1;
    in        = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Three set bits, free-running consumer
    send(8'b1010_0100);
    repeat (4) tick();

    // Backpressure holds the first beat
    send(8'h81);
    out_ready = 1'b0;
    repeat (4) tick();
    out_ready = 1'b1;
    repeat (3) tick();

    // Zero vector dropped, then all ones
    send(8'h00);
    tick();
    send(8'hFF);
    repeat (9) tick();

    // en low blocks acceptance
    en       = 1'b0;
    in       = 8'h3C;
    in_valid = 1'b1;
    repeat (2) tick();
    in_valid = 1'b0;
    en       = 1'b1;
    // en dropped mid-scan does not stall the drain
    send(8'h0F);
    en = 1'b0;
    repeat (5) tick();
    en = 1'b1;

    // Reset after the second beat
    send(8'hF0);
    repeat (2) tick();
    rst_n = 1'b0;
    q1.delete();
    q0.delete();
    #1;
    check_all();
    tick();
    rst_n = 1'b1;
    tick();
    send(8'h02);
    repeat (2) tick();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      en        = ($urandom_range(0, 7) != 0);
      in_valid  = $urandom_range(0, 1);
      in        = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        q1.delete();
        q0.delete();
        #1;
        check_all();
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
